ps2_letter_decoder: RTL and testbench

Upstream front end for the typing-game word checker. Receives raw PS/2 keyboard frames and decodes scan-code set 2 letter keys into the 5-bit letter code `kstrk`. On each letter-key release it emits a one-cycle key-release strobe `kr`, the same pair the checker consumes. Non-letter keys, extended (E0) keys and malformed frames never produce a strobe.

---
 rtl/ps2_letter_decoder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ps2_letter_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_letter_decoder.sv
// ps2_letter_decoder
// Front end for the typing-game word checker. Receives raw PS/2 keyboard
// frames, decodes scan-code set 2 letter-key releases into a 5-bit letter
// code (A=1 .. Z=26) and emits a one-cycle key-release strobe.
// Optional feature: define PS2_PARITY_CHECK_EN to enforce odd parity.
// When it is left undefined, the parity bit is captured but ignored.

module ps2_letter_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] kstrk,
    output logic       kr,
    output logic       perr
);

    typedef enum logic [1:0] {
        F_IDLE,
        F_DATA,
        F_PARITY,
        F_STOP
    } frameState_t;

    typedef enum logic [1:0] {
        B_NORM,
        B_BRK,
        B_EXT,
        B_EXTBRK
    } byteState_t;

    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);
    localparam logic [7:0]  CODE_BREAK    = 8'hF0;
    localparam logic [7:0]  CODE_EXTEND   = 8'hE0;

    // Synchronizer and edge-detect registers
    logic        clkSync1_q, clkSync2_q, clkPrev_q;
    logic        dataSync1_q, dataSync2_q;
    logic        fallEdge;

    // Frame receiver state and datapath
    frameState_t frameState_q, frameState_d;
    logic [7:0]  shift_q;
    logic [2:0]  bitCnt_q;
    logic        parityBit_q;
    logic [16:0] timeoutCnt_q;

    // Frame receiver control strobes
    logic        timeoutHit;
    logic        startEn;
    logic        shiftEn;
    logic        parityEn;
    logic        stopEval;
    logic        parityOdd;
    logic        parityOk;
    logic        frameGood;
    logic        frameBad;

    // Validated byte handed from the frame receiver to the byte decoder
    logic        byteValid_q;
    logic [7:0]  byte_q;

    // Byte decoder state and outputs
    byteState_t  byteState_q, byteState_d;
    logic [4:0]  letter;
    logic        strobe;
    logic [4:0]  kstrk_q;
    logic        kr_q;
    logic        perr_q;

    // Maps a set 2 scan code to its letter number, or 0 for any non-letter key.
    function automatic logic [4:0] letterOf(input logic [7:0] code);
        logic [4:0] l;
        l = 5'd0;
        case (code)
            8'h1C: l = 5'd1;
            8'h32: l = 5'd2;
            8'h21: l = 5'd3;
            8'h23: l = 5'd4;
            8'h24: l = 5'd5;
            8'h2B: l = 5'd6;
            8'h34: l = 5'd7;
            8'h33: l = 5'd8;
            8'h43: l = 5'd9;
            8'h3B: l = 5'd10;
            8'h42: l = 5'd11;
            8'h4B: l = 5'd12;
            8'h3A: l = 5'd13;
            8'h31: l = 5'd14;
            8'h44: l = 5'd15;
            8'h4D: l = 5'd16;
            8'h15: l = 5'd17;
            8'h2D: l = 5'd18;
            8'h1B: l = 5'd19;
            8'h2C: l = 5'd20;
            8'h3C: l = 5'd21;
            8'h2A: l = 5'd22;
            8'h1D: l = 5'd23;
            8'h22: l = 5'd24;
            8'h35: l = 5'd25;
            8'h1A: l = 5'd26;
            default: l = 5'd0;
        endcase
        return l;
    endfunction

    // Bring both PS/2 pins into the clk domain; idle-high reset avoids a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clkSync1_q  <= 1'b1;
            clkSync2_q  <= 1'b1;
            clkPrev_q   <= 1'b1;
            dataSync1_q <= 1'b1;
            dataSync2_q <= 1'b1;
        end else begin
            clkSync1_q  <= ps2_clk;
            clkSync2_q  <= clkSync1_q;
            clkPrev_q   <= clkSync2_q;
            dataSync1_q <= ps2_data;
            dataSync2_q <= dataSync1_q;
        end
    end

    assign fallEdge = clkPrev_q & ~clkSync2_q;

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frameState_q <= F_IDLE;
        end else begin
            frameState_q <= frameState_d;
        end
    end

    // Frame FSM next state: a timeout wins over a coincident edge and aborts the frame.
    always_comb begin
        frameState_d = frameState_q;
        if (timeoutHit) begin
            frameState_d = F_IDLE;
        end else if (fallEdge) begin
            case (frameState_q)
                F_IDLE:   if (!dataSync2_q) frameState_d = F_DATA;
                F_DATA:   if (bitCnt_q == 3'd7) frameState_d = F_PARITY;
                F_PARITY: frameState_d = F_STOP;
                F_STOP:   frameState_d = F_IDLE;
                default:  frameState_d = F_IDLE;
            endcase
        end
    end

    // Frame FSM outputs: per-edge datapath enables and the good/bad frame verdicts.
    always_comb begin
        timeoutHit = (frameState_q != F_IDLE) && (timeoutCnt_q == TIMEOUT_LIMIT);
        startEn    = fallEdge && !timeoutHit && (frameState_q == F_IDLE) && !dataSync2_q;
        shiftEn    = fallEdge && !timeoutHit && (frameState_q == F_DATA);
        parityEn   = fallEdge && !timeoutHit && (frameState_q == F_PARITY);
        stopEval   = fallEdge && !timeoutHit && (frameState_q == F_STOP);
        frameGood  = stopEval && dataSync2_q && parityOk;
        frameBad   = (stopEval && !(dataSync2_q && parityOk)) || timeoutHit;
    end

    // Odd parity over data plus parity bit; only enforced when the option is built in.
    assign parityOdd = ^{shift_q, parityBit_q};
`ifdef PS2_PARITY_CHECK_EN
    assign parityOk = parityOdd;
`else
    assign parityOk = parityOdd | 1'b1;
`endif

    // Shift register, bit counter and parity capture for the frame being received.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= 8'h00;
            bitCnt_q    <= 3'd0;
            parityBit_q <= 1'b0;
        end else begin
            if (startEn || timeoutHit) begin
                bitCnt_q <= 3'd0;
            end else if (shiftEn) begin
                shift_q  <= {dataSync2_q, shift_q[7:1]};
                bitCnt_q <= bitCnt_q + 3'd1;
            end
            if (parityEn) begin
                parityBit_q <= dataSync2_q;
            end
        end
    end

    // Watchdog on partial frames: counts idle cycles between edges while a frame is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeoutCnt_q <= 17'd0;
        end else if ((frameState_q == F_IDLE) || fallEdge || timeoutHit) begin
            timeoutCnt_q <= 17'd0;
        end else begin
            timeoutCnt_q <= timeoutCnt_q + 17'd1;
        end
    end

    // Hand a completed byte to the decoder and flag rejected frames for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            byteValid_q <= 1'b0;
            byte_q      <= 8'h00;
            perr_q      <= 1'b0;
        end else begin
            byteValid_q <= frameGood;
            perr_q      <= frameBad;
            if (frameGood) begin
                byte_q <= shift_q;
            end
        end
    end

    // Byte FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            byteState_q <= B_NORM;
        end else begin
            byteState_q <= byteState_d;
        end
    end

    // Byte FSM next state: tracks F0 / E0 prefixes across consecutive bytes.
    always_comb begin
        byteState_d = byteState_q;
        if (byteValid_q) begin
            case (byteState_q)
                B_NORM: begin
                    if (byte_q == CODE_BREAK) begin
                        byteState_d = B_BRK;
                    end else if (byte_q == CODE_EXTEND) begin
                        byteState_d = B_EXT;
                    end else begin
                        byteState_d = B_NORM;
                    end
                end
                B_BRK:    byteState_d = B_NORM;
                B_EXT:    byteState_d = (byte_q == CODE_BREAK) ? B_EXTBRK : B_NORM;
                B_EXTBRK: byteState_d = B_NORM;
                default:  byteState_d = B_NORM;
            endcase
        end
    end

    // Byte FSM outputs: only a letter code directly after a plain F0 is a release.
    always_comb begin
        letter = letterOf(byte_q);
        strobe = byteValid_q && (byteState_q == B_BRK) && (letter != 5'd0);
    end

    // Register the release strobe and hold the last released letter between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            kstrk_q <= 5'd0;
            kr_q    <= 1'b0;
        end else begin
            kr_q <= strobe;
            if (strobe) begin
                kstrk_q <= letter;
            end
        end
    end

    assign kstrk = kstrk_q;
    assign kr    = kr_q;
    assign perr  = perr_q;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// tb_ps2_letter_decoder
// Scoreboard bench: stimulus tasks push expected kr/perr events (with the
// cycle they must appear in) into a queue; a negedge monitor pops and
// compares every pulse the decoder produces.

module tb_ps2_letter_decoder;

    localparam int TIMEOUT = 200;

    localparam int EXP_NONE = 0;
    localparam int EXP_KR   = 1;
    localparam int EXP_PERR = 2;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] kstrk;
    logic       kr;
    logic       perr;

    exp_t sbQ[$];
    exp_t popped;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    ps2_letter_decoder #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .kstrk   (kstrk),
        .kr      (kr),
        .perr    (perr)
    );

    // 100 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index used to timestamp expected events.
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop if the run wanders off.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: every kr or perr pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (kr || perr)) begin
            compared++;
            if (sbQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_event: kr=%0d perr=%0d kstrk=%0d at cycle %0d, required no event",
                         kr, perr, kstrk, cyc);
            end else begin
                popped = sbQ.pop_front();
                if ((kr && perr) ||
                    (popped.kind == EXP_KR && !kr) ||
                    (popped.kind == EXP_PERR && !perr) ||
                    (popped.cyc >= 0 && popped.cyc != cyc) ||
                    (popped.kind == EXP_KR && int'(kstrk) != popped.val)) begin
                    mismatched++;
                    $display("[TB] FAIL event: got kr=%0d perr=%0d kstrk=%0d cycle=%0d, required kind=%0d kstrk=%0d cycle=%0d",
                             kr, perr, kstrk, cyc, popped.kind, popped.val, popped.cyc);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // One PS/2 bit: data set up, clock low for 20 cycles, then high again.
    task automatic driveBit(input logic b, input bit isStop, input int kind, input int val);
        ps2_data = b;
        repeat (10) @(negedge clk);
        if (isStop && kind != EXP_NONE) begin
            // Falling pin at cycle k: edge seen at k+2, perr at k+3, kr at k+4.
            sbQ.push_back(exp_t'{kind, (kind == EXP_KR) ? cyc + 4 : cyc + 3, val});
        end
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Full frame with optional parity or stop corruption and its expected event.
    task automatic applyStimulus(input logic [7:0] code, input bit badParity, input bit badStop,
                                 input int kind, input int val);
        logic p;
        p = (~^code) ^ badParity;
        driveBit(1'b0, 1'b0, EXP_NONE, 0);
        for (int i = 0; i < 8; i++) driveBit(code[i], 1'b0, EXP_NONE, 0);
        driveBit(p, 1'b0, EXP_NONE, 0);
        driveBit(~badStop, 1'b1, kind, val);
        ps2_data = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    // Start bit plus the first nBits data bits, then the line is left idle.
    task automatic drivePartial(input logic [7:0] code, input int nBits);
        driveBit(1'b0, 1'b0, EXP_NONE, 0);
        for (int i = 0; i < nBits; i++) driveBit(code[i], 1'b0, EXP_NONE, 0);
        ps2_data = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset_kstrk", int'(kstrk), 0);
        checkOutput("reset_kr", int'(kr), 0);
        checkOutput("reset_perr", int'(perr), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Make, typematic repeat, then release of A.
        applyStimulus(8'h1C, 1'b0, 1'b0, EXP_NONE, 0);
        applyStimulus(8'h1C, 1'b0, 1'b0, EXP_NONE, 0);
        applyStimulus(8'hF0, 1'b0, 1'b0, EXP_NONE, 0);
        applyStimulus(8'h1C, 1'b0, 1'b0, EXP_KR, 1);
        checkOutput("kstrk_after_A", int'(kstrk), 1);

        // Releases of Z then Q; Q must be held afterwards.
        applyStimulus(8'hF0, 1'b0, 1'b0, EXP_NONE, 0);
        applyStimulus(8'h1A, 1'b0, 1'b0, EXP_KR, 26);
        applyStimulus(8'hF0, 1'b0, 1'b0, EXP_NONE, 0);
        applyStimulus(8'h15, 1'b0, 1'b0, EXP_KR, 17);
        repeat (30) @(negedge clk);
        checkOutput("kstrk_hold_Q", int'(kstrk), 17);

        // Extended release and space release produce nothing.
        applyStimulus(8'hE0, 1'b0, 1'b0, EXP_NONE, 0);
        applyStimulus(8'hF0, 1'b0, 1'b0, EXP_NONE, 0);
        applyStimulus(8'h75, 1'b0, 1'b0, EXP_NONE, 0);
        applyStimulus(8'hF0, 1'b0, 1'b0, EXP_NONE, 0);
        applyStimulus(8'h29, 1'b0, 1'b0, EXP_NONE, 0);
        checkOutput("kstrk_after_nonletters", int'(kstrk), 17);

        // Bad stop bit is always rejected.
        applyStimulus(8'h1C, 1'b0, 1'b1, EXP_PERR, 0);

        // Wrong parity: rejected only when the check is built in.
`ifdef PS2_PARITY_CHECK_EN
        applyStimulus(8'h1C, 1'b1, 1'b0, EXP_PERR, 0);
`else
        applyStimulus(8'h1C, 1'b1, 1'b0, EXP_NONE, 0);
`endif
        applyStimulus(8'hF0, 1'b0, 1'b0, EXP_NONE, 0);
        applyStimulus(8'h1C, 1'b0, 1'b0, EXP_KR, 1);
        checkOutput("kstrk_after_parity_case", int'(kstrk), 1);

        // Abandoned frame times out with a single perr.
        sbQ.push_back(exp_t'{EXP_PERR, -1, 0});
        drivePartial(8'h3C, 5);
        repeat (TIMEOUT + 5) @(negedge clk);
        checkOutput("timeout_perr_seen", sbQ.size(), 0);
        applyStimulus(8'hF0, 1'b0, 1'b0, EXP_NONE, 0);
        applyStimulus(8'h24, 1'b0, 1'b0, EXP_KR, 5);
        checkOutput("kstrk_after_timeout", int'(kstrk), 5);

        // Reset in the middle of a release frame discards the F0 prefix.
        applyStimulus(8'hF0, 1'b0, 1'b0, EXP_NONE, 0);
        drivePartial(8'h1C, 4);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rst_mid_kstrk", int'(kstrk), 0);
        applyStimulus(8'h1C, 1'b0, 1'b0, EXP_NONE, 0);
        repeat (20) @(negedge clk);
        checkOutput("post_rst_kstrk", int'(kstrk), 0);
        checkOutput("post_rst_kr", int'(kr), 0);
        checkOutput("post_rst_perr", int'(perr), 0);

        checkOutput("scoreboard_drained", sbQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
